// File: rtl/cfg_pkg.sv
// Shared definitions for the Type 0 configuration request completer.
// Holds the FSM state encoding, completion status codes, completion
// fmt/type fields and the fixed byte count used by every completion.
package cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    RESP
  } cfg_state_t;

  localparam logic [2:0]  CPL_SC         = 3'b000;
  localparam logic [2:0]  CPL_UR         = 3'b001;

  localparam logic [2:0]  FMT_CPL        = 3'b000;
  localparam logic [2:0]  FMT_CPLD       = 3'b010;
  localparam logic [4:0]  TYPE_CPL       = 5'b01010;

  localparam logic [11:0] CPL_BYTE_COUNT = 12'd4;

endpackage

// File: rtl/cfg_be_merge.sv
// Combinational byte-enable merge plus write-protection mask for one
// configuration DW.
// Ports:
//   old_dw  - current register contents
//   new_dw  - write payload
//   be      - byte enables (1 = take byte from new_dw)
//   reg_num - DW register number being written
//   merged  - value to store back
module cfg_be_merge #(
  parameter int BAR0_BYTES_COUNT = 1024
) (
  input  logic [31:0] old_dw,
  input  logic [31:0] new_dw,
  input  logic [3:0]  be,
  input  logic [9:0]  reg_num,
  output logic [31:0] merged
);

  // BAR0 size bits read back as zero so software can size the aperture.
  localparam logic [31:0] BAR0_KEEP = ~(32'(BAR0_BYTES_COUNT) - 32'd1);

  logic [31:0] by_be;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      by_be[8*i +: 8] = be[i] ? new_dw[8*i +: 8] : old_dw[8*i +: 8];
    end

    merged = by_be;
    unique case (reg_num)
      10'd0, 10'd2: merged = old_dw;                       // ID / class code
      10'd3:        merged[23:16] = old_dw[23:16];         // header type
      10'd4:        merged = by_be & BAR0_KEEP;            // BAR0
      default:      merged = by_be;
    endcase
  end

endmodule

// File: rtl/cfg_tlp_responder.sv
// Completer for CfgRd0/CfgWr0 requests. Converts each accepted request
// into register-file cycles (read, or read-merge-write for writes) and
// returns one 3DW completion header, with a data DW for successful reads.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   completer_id        - our {bus,dev,func}, captured at accept
//   req_*               - request channel (valid/ready handshake)
//   cs_*                - register-file port (read data one cycle late)
//   cpl_*               - completion channel (valid/ready handshake)
module cfg_tlp_responder
  import cfg_pkg::*;
#(
  parameter int DW_COUNT         = 32,
  parameter int BAR0_BYTES_COUNT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [15:0]                 completer_id,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_is_write,
  input  logic [9:0]                  req_reg_num,
  input  logic [3:0]                  req_first_be,
  input  logic [31:0]                 req_data,
  input  logic [15:0]                 req_requester_id,
  input  logic [7:0]                  req_tag,
  output logic                        cs_wr_en,
  output logic [$clog2(DW_COUNT)-1:0] cs_addr,
  output logic [31:0]                 cs_data_in,
  input  logic [31:0]                 cs_data_out,
  output logic                        cpl_valid,
  input  logic                        cpl_ready,
  output logic [95:0]                 cpl_hdr,
  output logic [31:0]                 cpl_data,
  output logic                        cpl_has_data
);

  localparam int AW = $clog2(DW_COUNT);

  cfg_state_t  state, state_nxt;

  logic        cap_write;
  logic [9:0]  cap_reg_num;
  logic [3:0]  cap_be;
  logic [31:0] cap_data;
  logic [15:0] cap_rid;
  logic [7:0]  cap_tag;
  logic [15:0] cap_cid;
  logic [2:0]  cap_status;
  logic [31:0] rd_data;
  logic        has_data;
  logic [31:0] merged, merge_out;

  logic        accept;
  logic        out_of_range;

  assign accept       = req_valid && req_ready;
  assign out_of_range = 32'(req_reg_num) >= 32'(DW_COUNT);

  cfg_be_merge #(
    .BAR0_BYTES_COUNT(BAR0_BYTES_COUNT)
  ) u_merge (
    .old_dw (cs_data_out),
    .new_dw (cap_data),
    .be     (cap_be),
    .reg_num(cap_reg_num),
    .merged (merge_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    cs_wr_en  = 1'b0;
    cpl_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (out_of_range || (req_is_write && req_first_be == 4'd0))
            state_nxt = RESP;
          else
            state_nxt = READ;
        end
      end
      READ:  state_nxt = MERGE;
      MERGE: state_nxt = cap_write ? WRITE : RESP;
      WRITE: begin
        cs_wr_en  = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        cpl_valid = 1'b1;
        if (cpl_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture at accept; read data / merged value captured in MERGE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_write   <= 1'b0;
      cap_reg_num <= '0;
      cap_be      <= '0;
      cap_data    <= '0;
      cap_rid     <= '0;
      cap_tag     <= '0;
      cap_cid     <= '0;
      cap_status  <= CPL_SC;
      rd_data     <= '0;
      has_data    <= 1'b0;
      merged      <= '0;
    end else begin
      if (accept) begin
        cap_write   <= req_is_write;
        cap_reg_num <= req_reg_num;
        cap_be      <= req_first_be;
        cap_data    <= req_data;
        cap_rid     <= req_requester_id;
        cap_tag     <= req_tag;
        cap_cid     <= completer_id;
        cap_status  <= out_of_range ? CPL_UR : CPL_SC;
        rd_data     <= '0;
        has_data    <= 1'b0;
      end
      if (state == MERGE) begin
        if (cap_write) begin
          merged <= merge_out;
        end else begin
          rd_data  <= cs_data_out;
          has_data <= 1'b1;
        end
      end
    end
  end

  assign cs_addr    = cap_reg_num[AW-1:0];
  assign cs_data_in = merged;

  // Completion fields are zero outside RESP so idle outputs match reset.
  always_comb begin
    cpl_hdr      = '0;
    cpl_data     = '0;
    cpl_has_data = 1'b0;
    if (cpl_valid) begin
      cpl_hdr[95:64] = {has_data ? FMT_CPLD : FMT_CPL, TYPE_CPL, 14'd0,
                        has_data ? 10'd1 : 10'd0};
      cpl_hdr[63:32] = {cap_cid, cap_status, 1'b0, CPL_BYTE_COUNT};
      cpl_hdr[31:0]  = {cap_rid, cap_tag, 1'b0, 7'd0};
      cpl_data       = rd_data;
      cpl_has_data   = has_data;
    end
  end

endmodule

// File: doc/cfg_tlp_responder.md
# cfg_tlp_responder

Completer-side handler for Type 0 configuration requests (CfgRd0/CfgWr0). It sits between the transaction-layer request decoder and the configuration-space register file. It turns each request into register-file read/write cycles, with read-modify-write for partial byte enables, and returns exactly one completion TLP header plus optional data per request.

## Interface
- DW_COUNT, 32: number of config DWs implemented; register-file address width is $clog2(DW_COUNT).
- BAR0_BYTES_COUNT, 1024: BAR0 aperture size (power of 2); BAR0 bits [$clog2(BAR0_BYTES_COUNT)-1:0] are never written.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- completer_id  in  16  {bus, dev, func} of this function; sampled when a request is accepted.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_is_write  in  1  1 = CfgWr0, 0 = CfgRd0.
- req_reg_num  in  10  DW register number ({ext_reg, reg}).
- req_first_be  in  4  first-DW byte enables.
- req_data  in  32  write payload.
- req_requester_id  in  16  requester ID, echoed in the completion.
- req_tag  in  8  tag, echoed in the completion.
- cs_wr_en  out  1  register-file write strobe.
- cs_addr  out  $clog2(DW_COUNT)  register-file address.
- cs_data_in  out  32  register-file write data.
- cs_data_out  in  32  register-file read data, registered, valid 1 cycle after cs_addr.
- cpl_valid  out  1  completion present.
- cpl_ready  in  1  completion taken when cpl_valid && cpl_ready.
- cpl_hdr  out  96  {DW0, DW1, DW2} of the 3DW completion header.
- cpl_data  out  32  payload; meaningful only for CplD.
- cpl_has_data  out  1  1 = CplD, 0 = Cpl.

## Operation
- FSM states: IDLE, READ, MERGE, WRITE, RESP.
- IDLE: req_ready=1. On accept, capture all req_* fields and completer_id.
  - reg_num >= DW_COUNT: status UR, go to RESP.
  - Write with first_be==0: status SC, go to RESP; no register access.
  - Otherwise: go to READ.
- READ: drive cs_addr=reg_num[$clog2(DW_COUNT)-1:0]. Next state is MERGE.
- MERGE: cs_data_out is valid.
  - Read: latch it into cpl_data, status SC, go to RESP.
  - Write: compute merged = per byte (be ? req_data : old), then apply the write mask, then go to WRITE.
- Write mask:
  - DW0 and DW2 are read-only; keep the old value.
  - DW3 byte 2 (header type) is read-only.
  - DW4 bits [$clog2(BAR0_BYTES_COUNT)-1:0] are forced to 0.
- WRITE: cs_wr_en=1 for exactly one cycle with merged data. Next state is RESP with status SC.
- RESP: cpl_valid=1, all completion outputs held stable until cpl_ready; then go to IDLE.
- DW0 = {3'b010 for CplD / 3'b000 for Cpl, 5'b01010, 14'b0, length 10'd1 for CplD / 10'd0 for Cpl}.
- DW1 = {completer_id, status[2:0] (SC=000, UR=001), BCM=0, byte_count=12'd4}.
- DW2 = {requester_id, tag, 1'b0, lower_addr=7'd0}.
- CplD only for a successful read; a UR read returns Cpl with cpl_data=0.

## Timing
- Reset values: FSM=IDLE; req_ready=1; cs_wr_en=0; cs_addr=0; cs_data_in=0; cpl_valid=0; cpl_hdr=0; cpl_data=0; cpl_has_data=0.
- Accept to cpl_valid:
  - read: 3 cycles (IDLE→READ→MERGE→RESP).
  - write: 4 cycles.
  - UR or BE=0 write: 1 cycle.
- cs_wr_en asserts only in WRITE: at most one pulse per request, never on a UR request.
- req_ready=0 in every non-IDLE state; a single outstanding request.
- Back-to-back: the first accept after a cpl handshake is in the cycle after cpl_ready, since IDLE is re-entered.
- cpl_ready held high: completion lasts exactly one cycle.
- cpl_ready low: outputs frozen indefinitely.
- Reset mid-operation: abort immediately with outputs at reset values. No completion and no write is issued for the aborted request. A WRITE-state cycle coinciding with reset asserting produces no write.

## Structure
- Package cfg_pkg holds:
  - state enum (IDLE, READ, MERGE, WRITE, RESP);
  - completion status constants (CPL_SC, CPL_UR);
  - fmt/type constants (FMT_CPL, FMT_CPLD, TYPE_CPL);
  - CPL_BYTE_COUNT=4.
- Sub-module cfg_be_merge: combinational, (old, new, be, reg_num) → masked merged DW. Verified standalone.

## Test plan
- Read DW0 holding 0x1234_ABCD, requester 0x0100, tag 0x05, completer 0x0200 → CplD 3 cycles after accept. DW0=0x4A000001, DW1=0x02000004, DW2=0x01000500, data=0x1234ABCD.
- Write 0xFFFF_FFFF to DW4, BE=0xF, BAR0_BYTES_COUNT=1024, then read DW4 → one cs_wr_en pulse with 0xFFFFFC00; read returns 0xFFFFFC00; Cpl DW0=0x0A000000, status SC.
- Write 0xAABBCCDD to DW5 (old 0x11223344) with BE=0x5 → cs_data_in=0x11BB33DD.
- Read reg_num=40 with DW_COUNT=32 → Cpl with status UR (DW1[15:13]=001), no cs_wr_en, cpl_valid 1 cycle after accept.
- Hold cpl_ready=0 for 10 cycles → cpl_* stable and req_ready=0 throughout; a pending second request is accepted the cycle after the handshake.
- Assert rst in the MERGE state of a write → no cs_wr_en, cpl_valid stays 0, req_ready=1 after release.
